// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and the rest of the game:
// frame/event inputs in, motion enable and scoreboard outputs back.
interface game_sequencer_if;
    logic       tick;
    logic       start;
    logic       brick_hit;
    logic       ball_lost;
    logic       run;
    logic       ball_rst;
    logic [1:0] lives;
    logic [9:0] score;
    logic [5:0] bricks_left;
    logic [2:0] state;
    logic       game_over;
    logic       win;

    modport master (
        output tick, start, brick_hit, ball_lost,
        input  run, ball_rst, lives, score, bricks_left,
        input  state, game_over, win
    );

    modport slave (
        input  tick, start, brick_hit, ball_lost,
        output run, ball_rst, lives, score, bricks_left,
        output state, game_over, win
    );
endinterface

// File: rtl/game_sequencer.sv
// Breakout-style game flow controller: serve delay, play, pause,
// life loss, game over and win, with lives/score/brick bookkeeping.
module game_sequencer #(
    parameter int LIVES       = 3,
    parameter int SERVE_TICKS = 60,
    parameter int BRICKS      = 40
) (
    input  logic              clk,
    input  logic              rst,
    game_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5,
        S_PAUSE = 3'd6
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt;
    logic [1:0] r_lives, w_lives;
    logic [9:0] r_score, w_score;
    logic [5:0] r_bricks, w_bricks;
    logic       r_start_q;
    logic       r_armed;
    logic       r_ball_rst;
    logic       w_press;
    logic       w_serve_entry;

    // r_armed blocks a button that is still held low from before reset
    assign w_press = r_armed & r_start_q & ~bus.start;
    assign w_serve_entry = (w_next == S_SERVE) && (r_state != S_SERVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_start_q  <= 1'b1;
            r_armed    <= 1'b0;
            r_lives    <= 2'(LIVES);
            r_score    <= 10'd0;
            r_bricks   <= 6'(BRICKS);
            r_ball_rst <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt;
            r_start_q  <= bus.start;
            r_armed    <= r_armed | bus.start;
            r_lives    <= w_lives;
            r_score    <= w_score;
            r_bricks   <= w_bricks;
            r_ball_rst <= w_serve_entry;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_cnt    = r_cnt;
        w_lives  = r_lives;
        w_score  = r_score;
        w_bricks = r_bricks;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_next   = S_SERVE;
                    w_lives  = 2'(LIVES);
                    w_score  = 10'd0;
                    w_bricks = 6'(BRICKS);
                end
            end
            S_SERVE: begin
                if (bus.tick) begin
                    if (r_cnt == 8'd0) w_next = S_PLAY;
                    else               w_cnt  = r_cnt - 8'd1;
                end
            end
            S_PLAY: begin
                if (bus.brick_hit) begin
                    if (r_score != 10'h3FF) w_score = r_score + 10'd1;
                    w_bricks = r_bricks - 6'd1;
                end
                if (bus.brick_hit && (r_bricks == 6'd1)) w_next = S_WIN;
                else if (bus.ball_lost)                  w_next = S_LOST;
                else if (w_press)                        w_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_press) w_next = S_PLAY;
            end
            S_LOST: begin
                if (r_lives <= 2'd1) begin
                    w_next  = S_OVER;
                    w_lives = 2'd0;
                end else begin
                    w_next  = S_SERVE;
                    w_lives = r_lives - 2'd1;
                end
            end
            S_OVER, S_WIN: begin
                if (w_press) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // every way into SERVE restarts the serve delay
        if (w_serve_entry) w_cnt = 8'(SERVE_TICKS);
    end

    assign bus.run         = (r_state == S_PLAY);
    assign bus.ball_rst    = r_ball_rst;
    assign bus.lives       = r_lives;
    assign bus.score       = r_score;
    assign bus.bricks_left = r_bricks;
    assign bus.state       = r_state;
    assign bus.game_over   = (r_state == S_OVER);
    assign bus.win         = (r_state == S_WIN);
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: serve timing, scoring,
// pause, life loss, win priority and mid-game reset.
module tb_game_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    game_sequencer_if g();

    game_sequencer #(
        .LIVES(3),
        .SERVE_TICKS(60),
        .BRICKS(40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (g.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press();
        g.start = 1'b0;
        step();
        g.start = 1'b1;
        step();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            g.tick = 1'b1;
            step();
            g.tick = 1'b0;
            step();
        end
    endtask

    task automatic lose_ball();
        g.ball_lost = 1'b1;
        step();
        g.ball_lost = 1'b0;
        chk("lost_state", int'(g.state), 3);
        step();
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        g.tick      = 1'b0;
        g.start     = 1'b1;
        g.brick_hit = 1'b0;
        g.ball_lost = 1'b0;
        #23;
        chk("rst_state", int'(g.state), 0);
        chk("rst_lives", int'(g.lives), 3);
        chk("rst_score", int'(g.score), 0);
        chk("rst_bricks", int'(g.bricks_left), 40);
        chk("rst_run", int'(g.run), 0);
        chk("rst_ball_rst", int'(g.ball_rst), 0);
        chk("rst_over_win", int'({g.game_over, g.win}), 0);
        rst = 1'b1;
        step(3);

        // first game: serve delay of 61 ticks
        g.start = 1'b0;
        step();
        chk("serve_state", int'(g.state), 1);
        chk("serve_ball_rst", int'(g.ball_rst), 1);
        g.start = 1'b1;
        step();
        chk("serve_ball_rst_end", int'(g.ball_rst), 0);
        ticks(60);
        chk("serve_60_state", int'(g.state), 1);
        chk("serve_60_run", int'(g.run), 0);
        ticks(1);
        chk("play_state", int'(g.state), 2);
        chk("play_run", int'(g.run), 1);

        repeat (3) begin
            g.brick_hit = 1'b1;
            step();
            g.brick_hit = 1'b0;
            step();
        end
        chk("hit3_score", int'(g.score), 3);
        chk("hit3_bricks", int'(g.bricks_left), 37);
        chk("hit3_state", int'(g.state), 2);

        // pause ignores game events
        press();
        chk("pause_state", int'(g.state), 6);
        chk("pause_run", int'(g.run), 0);
        g.ball_lost = 1'b1;
        g.brick_hit = 1'b1;
        step(2);
        g.ball_lost = 1'b0;
        g.brick_hit = 1'b0;
        chk("pause_hold", int'(g.state), 6);
        chk("pause_score", int'(g.score), 3);
        chk("pause_bricks", int'(g.bricks_left), 37);
        press();
        chk("resume_state", int'(g.state), 2);
        chk("resume_run", int'(g.run), 1);
        chk("resume_score", int'(g.score), 3);

        // three lost balls
        lose_ball();
        chk("lose1_state", int'(g.state), 1);
        chk("lose1_lives", int'(g.lives), 2);
        chk("lose1_ball_rst", int'(g.ball_rst), 1);
        ticks(61);
        chk("lose1_play", int'(g.state), 2);
        lose_ball();
        chk("lose2_lives", int'(g.lives), 1);
        chk("lose2_ball_rst", int'(g.ball_rst), 1);
        ticks(61);
        lose_ball();
        chk("over_state", int'(g.state), 4);
        chk("over_lives", int'(g.lives), 0);
        chk("over_flag", int'(g.game_over), 1);
        chk("over_run", int'(g.run), 0);
        press();
        chk("over_to_idle", int'(g.state), 0);
        chk("idle_score_kept", int'(g.score), 3);

        // second game: clear the level with a simultaneous loss
        g.start = 1'b0;
        step();
        chk("g2_score", int'(g.score), 0);
        chk("g2_bricks", int'(g.bricks_left), 40);
        chk("g2_lives", int'(g.lives), 3);
        g.start = 1'b1;
        step();
        ticks(61);
        g.brick_hit = 1'b1;
        step(39);
        g.brick_hit = 1'b0;
        chk("g2_bricks1", int'(g.bricks_left), 1);
        chk("g2_score39", int'(g.score), 39);
        g.brick_hit = 1'b1;
        g.ball_lost = 1'b1;
        step();
        g.brick_hit = 1'b0;
        g.ball_lost = 1'b0;
        chk("win_state", int'(g.state), 5);
        chk("win_flag", int'(g.win), 1);
        chk("win_bricks", int'(g.bricks_left), 0);
        chk("win_lives", int'(g.lives), 3);
        chk("win_score", int'(g.score), 40);
        g.brick_hit = 1'b1;
        step();
        g.brick_hit = 1'b0;
        chk("win_hit_ignored", int'(g.score), 40);
        press();
        chk("win_to_idle", int'(g.state), 0);

        // reset in the middle of serve, button held through release
        press();
        ticks(30);
        chk("mid_serve", int'(g.state), 1);
        g.start = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_state", int'(g.state), 0);
        chk("mid_rst_ball_rst", int'(g.ball_rst), 0);
        chk("mid_rst_lives", int'(g.lives), 3);
        chk("mid_rst_score", int'(g.score), 0);
        step();
        rst = 1'b1;
        step(4);
        chk("held_no_press", int'(g.state), 0);
        chk("held_no_ball_rst", int'(g.ball_rst), 0);
        g.start = 1'b1;
        step();
        g.start = 1'b0;
        step();
        chk("repress_state", int'(g.state), 1);
        chk("repress_ball_rst", int'(g.ball_rst), 1);
        g.start = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
